// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the MCP3002-class SPI sampler.
package adc_spi_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StShift,
      StHold
   } state_t;

   localparam int unsigned FRAME_BITS     = 16;
   localparam int unsigned CMD_BITS       = 4;
   localparam int unsigned DATA_FIRST_BIT = 6;
   localparam int unsigned DATA_WIDTH     = 10;

   // Command word sent MSB first: start, single-ended, channel, MSB-first format.
   function automatic logic [CMD_BITS-1:0] build_cmd(input logic ch);
      return {1'b1, 1'b1, ch, 1'b1};
   endfunction

endpackage

// File: rtl/adc_spi_sampler_if.sv
// ADC pin bundle plus the sample output bus toward the echo processor.
interface adc_spi_sampler_if;
   import adc_spi_pkg::*;

   logic                  adc_cs_n;
   logic                  adc_sck;
   logic                  adc_mosi;
   logic                  adc_miso;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_valid;
   logic                  busy;

   modport master (
      output adc_cs_n,
      output adc_sck,
      output adc_mosi,
      input  adc_miso,
      output data_out,
      output data_valid,
      output busy
   );

   modport slave (
      input  adc_cs_n,
      input  adc_sck,
      input  adc_mosi,
      output adc_miso,
      input  data_out,
      input  data_valid,
      input  busy
   );

endinterface

// File: rtl/spi_half_tick.sv
// Emits a one-cycle strobe every CLK_DIV cycles while enabled; clears when disabled.
module spi_half_tick #(
   parameter int unsigned CLK_DIV = 25
) (
   input  logic sysclk,
   input  logic rst_n,
   input  logic enable,
   output logic strobe
);

   localparam int unsigned CW = $clog2(CLK_DIV);

   logic [CW-1:0] cnt_q, cnt_d;

   // Strobe on the last count of each half period and restart the count.
   always_comb begin
      strobe = enable && (cnt_q == CW'(CLK_DIV - 1));
      cnt_d  = cnt_q;
      if (!enable || strobe) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Half-period counter register.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/adc_spi_sampler.sv
// Periodic single-conversion SPI master for an MCP3002-class 10-bit ADC.
module adc_spi_sampler
   import adc_spi_pkg::*;
#(
   parameter int unsigned CLK_DIV       = 25,
   parameter int unsigned SAMPLE_PERIOD = 5000
) (
   input  logic                sysclk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                ch_sel,
   adc_spi_sampler_if.master   bus
);

   localparam int unsigned TW = $clog2(SAMPLE_PERIOD);

   if (CLK_DIV < 4) begin : g_bad_div
      $error("CLK_DIV must be at least 4");
   end
   if (SAMPLE_PERIOD < 33 * CLK_DIV + 2) begin : g_bad_period
      $error("SAMPLE_PERIOD shorter than one full frame");
   end

   state_t                state_q, state_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic                  miso_meta_q, miso_sync_q;
   logic                  cs_n_q, cs_n_d;
   logic                  sck_q, sck_d;
   logic [CMD_BITS-1:0]   cmd_q, cmd_d;
   logic [4:0]            edge_q, edge_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  tick;
   logic                  start;
   logic                  half_tick;
   logic [3:0]            bit_idx;

   assign tick    = (timer_q == TW'(SAMPLE_PERIOD - 1));
   assign start   = tick && en && (state_q == StIdle);
   // Even edge numbers are rising edges, so edge/2 is the SCK period index k.
   assign bit_idx = edge_q[4:1];

   spi_half_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_half_tick (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .enable (state_q != StIdle),
      .strobe (half_tick)
   );

   // Free-running sample timer, independent of en.
   always_comb begin
      timer_d = tick ? '0 : timer_q + TW'(1);
   end

   // Frame sequencing, SCK/MOSI generation and MISO assembly.
   always_comb begin
      state_d = state_q;
      cs_n_d  = cs_n_q;
      sck_d   = sck_q;
      cmd_d   = cmd_q;
      edge_d  = edge_q;
      word_d  = word_q;
      data_d  = data_q;
      valid_d = valid_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StSetup;
               cs_n_d  = 1'b0;
               valid_d = 1'b0;
               // Command bit 0 goes out immediately; mosi is cmd_q MSB.
               cmd_d   = build_cmd(ch_sel);
            end
         end
         StSetup: begin
            if (half_tick) begin
               state_d = StShift;
               sck_d   = 1'b1;
               edge_d  = '0;
            end
         end
         StShift: begin
            if (half_tick) begin
               if (sck_q) begin
                  // End of a high phase: sample MISO, drop SCK, advance MOSI.
                  if (bit_idx >= 4'(DATA_FIRST_BIT)) begin
                     word_d[4'(FRAME_BITS - 1) - bit_idx] = miso_sync_q;
                  end
                  sck_d = 1'b0;
                  cmd_d = {cmd_q[CMD_BITS-2:0], 1'b0};
                  if (edge_q == 5'(2 * FRAME_BITS - 2)) begin
                     state_d = StHold;
                     data_d  = word_d;
                     valid_d = 1'b1;
                  end else begin
                     edge_d = edge_q + 5'd1;
                  end
               end else begin
                  sck_d  = 1'b1;
                  edge_d = edge_q + 5'd1;
               end
            end
         end
         StHold: begin
            if (half_tick) begin
               state_d = StIdle;
               cs_n_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset aborts any frame in progress.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         timer_q     <= '0;
         miso_meta_q <= 1'b0;
         miso_sync_q <= 1'b0;
         cs_n_q      <= 1'b1;
         sck_q       <= 1'b0;
         cmd_q       <= '0;
         edge_q      <= '0;
         word_q      <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         miso_meta_q <= bus.adc_miso;
         miso_sync_q <= miso_meta_q;
         cs_n_q      <= cs_n_d;
         sck_q       <= sck_d;
         cmd_q       <= cmd_d;
         edge_q      <= edge_d;
         word_q      <= word_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
      end
   end

   assign bus.adc_cs_n   = cs_n_q;
   assign bus.adc_sck    = sck_q;
   assign bus.adc_mosi   = cmd_q[CMD_BITS-1];
   assign bus.data_out   = data_q;
   assign bus.data_valid = valid_q;
   assign bus.busy       = ~cs_n_q;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Directed bench for adc_spi_sampler with a behavioural MCP3002 model.
module tb_adc_spi_sampler;

   localparam int unsigned CLK_DIV = 25;
   localparam int unsigned SP      = 5000;

   logic sysclk = 1'b0;
   logic rst_n  = 1'b0;
   logic en     = 1'b0;
   logic ch_sel = 1'b0;

   adc_spi_sampler_if bus ();

   adc_spi_sampler #(
      .CLK_DIV       (CLK_DIV),
      .SAMPLE_PERIOD (SP)
   ) dut (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .en     (en),
      .ch_sel (ch_sel),
      .bus    (bus)
   );

   always #5 sysclk = ~sysclk;

   int checks = 0;
   int passes = 0;
   int fails  = 0;
   int cyc    = 0;
   int rel_cyc;
   int ref_cyc;

   always @(posedge sysclk) cyc <= cyc + 1;

   // Edge monitor sampled on the falling sysclk edge.
   logic        prev_cs_n = 1'b1, prev_dv = 1'b0, prev_sck = 1'b0;
   int          cs_fall_cnt = 0, cs_rise_cnt = 0, dv_rise_cnt = 0, dv_fall_cnt = 0;
   int          cs_fall_cyc = 0, cs_prev_fall_cyc = 0, cs_rise_cyc = 0;
   int          dv_rise_cyc = 0, dv_fall_cyc = 0;
   int          sck_rise_total = 0, frame_rises = 0, frame_falls = 0;
   logic [15:0] mosi_bits = '0;
   logic [9:0]  adc_word = '0;

   always @(negedge sysclk) begin
      if (prev_cs_n && !bus.adc_cs_n) begin
         cs_fall_cnt      <= cs_fall_cnt + 1;
         cs_prev_fall_cyc <= cs_fall_cyc;
         cs_fall_cyc      <= cyc;
         frame_rises      <= 0;
         frame_falls      <= 0;
      end else begin
         if (!prev_sck && bus.adc_sck) begin
            frame_rises <= frame_rises + 1;
            if (frame_rises < 16) mosi_bits[frame_rises] <= bus.adc_mosi;
         end
         if (prev_sck && !bus.adc_sck) frame_falls <= frame_falls + 1;
      end
      if (!prev_cs_n && bus.adc_cs_n) begin
         cs_rise_cnt <= cs_rise_cnt + 1;
         cs_rise_cyc <= cyc;
      end
      if (!prev_dv && bus.data_valid) begin
         dv_rise_cnt <= dv_rise_cnt + 1;
         dv_rise_cyc <= cyc;
      end
      if (prev_dv && !bus.data_valid) begin
         dv_fall_cnt <= dv_fall_cnt + 1;
         dv_fall_cyc <= cyc;
      end
      if (!prev_sck && bus.adc_sck) sck_rise_total <= sck_rise_total + 1;
      prev_cs_n <= bus.adc_cs_n;
      prev_dv   <= bus.data_valid;
      prev_sck  <= bus.adc_sck;
   end

   // ADC model: bit k is presented after k falling SCK edges; k<6 are don't-care ones.
   function automatic logic model_bit(input int k, input logic [9:0] w);
      if (k >= 6 && k <= 15) return w[15-k];
      return 1'b1;
   endfunction

   assign bus.adc_miso = model_bit(frame_falls, adc_word);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge sysclk);
      #1;
   endtask

   function automatic int get_cnt(input int which);
      case (which)
         0:       return cs_fall_cnt;
         1:       return dv_rise_cnt;
         2:       return cs_rise_cnt;
         default: return frame_rises;
      endcase
   endfunction

   // Bounded wait; an expired bound is recorded as a failed comparison.
   task automatic wait_evt(input int which, input int target, input int limit, input string tag);
      int n = 0;
      while (get_cnt(which) < target && n < limit) begin
         step();
         n++;
      end
      check(tag, 32'(get_cnt(which) >= target), 32'd1);
   endtask

   function automatic logic [14:0] outs();
      return {bus.adc_cs_n, bus.adc_sck, bus.adc_mosi, bus.data_valid, bus.busy, bus.data_out};
   endfunction

   initial begin
      #(900_000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held with en low: everything idle.
      for (int i = 0; i < 10; i++) begin
         step();
         check("reset_outs", 32'(outs()), 32'h4000);
      end
      check("reset_no_sck", 32'(sck_rise_total), 32'd0);

      // Frame 1: CH0, word 0x2A5.
      en       = 1'b1;
      adc_word = 10'h2A5;
      @(negedge sysclk);
      rst_n   = 1'b1;
      rel_cyc = cyc;
      repeat (50) step();
      check("idle_after_rel", 32'(outs()), 32'h4000);
      wait_evt(0, 1, 5100, "wait_f1_start");
      check("f1_start_cycle", 32'(cs_fall_cyc - rel_cyc), 32'd5000);
      check("f1_busy", 32'(bus.busy), 32'd1);
      wait_evt(1, 1, 900, "wait_f1_load");
      check("f1_latency", 32'(dv_rise_cyc - cs_fall_cyc), 32'd800);
      check("f1_data", 32'(bus.data_out), 32'h2A5);
      check("f1_mosi", 32'(mosi_bits), 32'h000B);
      wait_evt(2, 1, 100, "wait_f1_end");
      check("f1_cs_len", 32'(cs_rise_cyc - cs_fall_cyc), 32'd825);
      check("f1_sck_count", 32'(frame_rises), 32'd16);
      check("f1_idle", 32'({bus.busy, bus.adc_sck}), 32'd0);

      // Frame 2: CH1, full scale; data_valid falls with chip select.
      ch_sel   = 1'b1;
      adc_word = 10'h3FF;
      wait_evt(0, 2, 5100, "wait_f2_start");
      check("f2_period", 32'(cs_fall_cyc - cs_prev_fall_cyc), 32'd5000);
      check("f2_dv_fall_at_cs", 32'(dv_fall_cyc), 32'(cs_fall_cyc));
      check("f2_old_data_held", 32'(bus.data_out), 32'h2A5);
      wait_evt(1, 2, 900, "wait_f2_load");
      check("f2_data", 32'(bus.data_out), 32'h3FF);
      check("f2_mosi", 32'(mosi_bits), 32'h000F);

      // Frame 3: zero scale.
      adc_word = 10'h000;
      wait_evt(0, 3, 5100, "wait_f3_start");
      check("f3_period", 32'(cs_fall_cyc - cs_prev_fall_cyc), 32'd5000);
      wait_evt(1, 3, 900, "wait_f3_load");
      check("f3_data", 32'(bus.data_out), 32'h000);

      // Frames 4 and 5: alternating patterns, back on CH0.
      ch_sel   = 1'b0;
      adc_word = 10'h155;
      wait_evt(0, 4, 5100, "wait_f4_start");
      check("f4_period", 32'(cs_fall_cyc - cs_prev_fall_cyc), 32'd5000);
      wait_evt(1, 4, 900, "wait_f4_load");
      check("f4_data", 32'(bus.data_out), 32'h155);
      check("f4_mosi", 32'(mosi_bits), 32'h000B);
      adc_word = 10'h2AA;
      wait_evt(0, 5, 5100, "wait_f5_start");
      check("f5_period", 32'(cs_fall_cyc - cs_prev_fall_cyc), 32'd5000);
      wait_evt(1, 5, 900, "wait_f5_load");
      check("f5_data", 32'(bus.data_out), 32'h2AA);
      check("five_dv_rises", 32'(dv_rise_cnt), 32'd5);
      check("four_dv_falls", 32'(dv_fall_cnt), 32'd4);

      // Frame 6: en dropped at k=8; frame completes, next tick is skipped.
      adc_word = 10'h1C3;
      wait_evt(0, 6, 5100, "wait_f6_start");
      wait_evt(3, 9, 600, "wait_f6_k8");
      en = 1'b0;
      wait_evt(1, 6, 900, "wait_f6_load");
      check("f6_data", 32'(bus.data_out), 32'h1C3);
      ref_cyc = cs_fall_cyc;
      while (cyc < ref_cyc + 5100) step();
      check("en_low_no_start", 32'(cs_fall_cnt), 32'd6);
      check("en_low_valid_held", 32'({bus.data_valid, bus.busy, bus.data_out}), 32'h9C3);

      // Re-enable: resumes on the following tick.
      en       = 1'b1;
      adc_word = 10'h0F0;
      wait_evt(0, 7, 5100, "wait_f7_start");
      check("f7_resume", 32'(cs_fall_cyc - ref_cyc), 32'd10000);
      wait_evt(1, 7, 900, "wait_f7_load");
      check("f7_data", 32'(bus.data_out), 32'h0F0);

      // Frame 8: reset asserted at k=10 aborts immediately.
      adc_word = 10'h3C3;
      wait_evt(0, 8, 5100, "wait_f8_start");
      wait_evt(3, 11, 700, "wait_f8_k10");
      rst_n = 1'b0;
      #1;
      check("abort_outs", 32'(outs()), 32'h4000);
      repeat (5) step();
      check("abort_held", 32'(outs()), 32'h4000);
      @(negedge sysclk);
      rst_n   = 1'b1;
      rel_cyc = cyc;
      wait_evt(0, 9, 5100, "wait_f9_start");
      check("post_reset_start", 32'(cs_fall_cyc - rel_cyc), 32'd5000);
      wait_evt(1, 8, 900, "wait_f9_load");
      check("f9_data", 32'(bus.data_out), 32'h3C3);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
